// File: rtl/tx_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_share_arbiter_pkg
//  Description : Shared types and constants for the shared UART transmitter:
//                serializer state encoding, status-path byte codes and the
//                default 921600-baud bit period at 50 MHz.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_share_arbiter_pkg;

    // Serializer frame states (explicit 2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Codes carried by the status/error requester.
    localparam logic [7:0] STAT_OVERRUN = 8'hAA;
    localparam logic [7:0] STAT_STOPERR = 8'hBB;

    // 50e6 / 921600 = 54.25, rounded down to 54 clocks per bit.
    localparam int CLKS_921600 = 54;

endpackage
`default_nettype wire

// File: rtl/tx_share_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : tx_share_arbiter_if
//  Description : Requester-side bundle of the shared UART transmitter.
//                Ports:
//                  data_valid/data_byte/data_ready : decoded-data requester
//                  stat_valid/stat_byte/stat_ready : status/error requester
//                  halt                            : stop issuing grants
//                  RS232_DCE_TXD                   : serial line, idle high
//                  busy                            : frame in flight
//                  owner                           : 0 = data, 1 = status
//                Modport master = requesters / line consumer, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tx_share_arbiter_if;
    import tx_share_arbiter_pkg::*;

    logic       data_valid;
    logic [7:0] data_byte;
    logic       data_ready;
    logic       stat_valid;
    logic [7:0] stat_byte;
    logic       stat_ready;
    logic       halt;
    logic       RS232_DCE_TXD;
    logic       busy;
    logic       owner;

    modport master (
        output data_valid, data_byte, stat_valid, stat_byte, halt,
        input  data_ready, stat_ready, RS232_DCE_TXD, busy, owner
    );

    modport slave (
        input  data_valid, data_byte, stat_valid, stat_byte, halt,
        output data_ready, stat_ready, RS232_DCE_TXD, busy, owner
    );

endinterface
`default_nettype wire

// File: rtl/tx_share_arbiter_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : 8N1 UART frame serializer. A one-cycle i_load in IDLE
//                captures i_byte; the line then carries start (0), 8 data
//                bits LSB first and stop (1), each for CLKS_PER_BIT clocks.
//                Ports:
//                  CLK_50M, RST : clock, synchronous active-high reset
//                  i_load       : start a frame (honoured in IDLE only)
//                  i_byte       : byte to send, sampled with i_load
//                  o_txd        : registered serial output, idle high
//                  o_done       : high in the last cycle of the stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import tx_share_arbiter_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_921600,
    parameter int CNT_W        = 13
) (
    input  wire logic       CLK_50M,
    input  wire logic       RST,
    input  wire logic       i_load,
    input  wire logic [7:0] i_byte,
    output logic            o_txd,
    output logic            o_done
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]       r_idx,   w_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_txd,   w_txd_nxt;
    logic             w_wrap;
    logic             w_done;

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // The line value is computed for the next state and registered, so the
    // pin never glitches and changes exactly on bit boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_done      = 1'b0;
        w_wrap      = (r_cnt == c_cnt_last);

        if (r_state != ST_IDLE) begin
            w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                w_txd_nxt = 1'b1;
                if (i_load) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_shift_nxt = i_byte;
                    w_txd_nxt   = 1'b0;
                end
            end
            ST_START: begin
                if (w_wrap) begin
                    w_state_nxt = ST_DATA;
                    w_idx_nxt   = 3'd0;
                    w_txd_nxt   = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_wrap) begin
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_txd_nxt   = r_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (w_wrap) begin
                    w_state_nxt = ST_IDLE;
                    w_txd_nxt   = 1'b1;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    assign o_txd  = r_txd;
    assign o_done = w_done;

endmodule
`default_nettype wire

// File: rtl/tx_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tx_share_arbiter
//  Description : Shares one 8N1 UART transmitter between the decoded-data
//                requester and the status/error requester with round-robin
//                grant, a valid/ready byte handshake and a grant halt.
//                Ports:
//                  CLK_50M : system clock, rising edge
//                  RST     : synchronous active-high reset
//                  bus     : tx_share_arbiter_if.slave (requester handshakes,
//                            halt, RS232_DCE_TXD, busy, owner)
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_share_arbiter
    import tx_share_arbiter_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_921600,
    parameter int CNT_W        = 13
) (
    input  wire logic          CLK_50M,
    input  wire logic          RST,
    tx_share_arbiter_if.slave  bus
);

    logic       r_busy;
    logic       r_owner;
    logic       r_last_grant;   // 0 = data granted last, 1 = status
    logic       w_grant_ok;
    logic       w_data_ready;
    logic       w_stat_ready;
    logic       w_load;
    logic [7:0] w_byte;
    logic       w_done;
    logic       w_txd;

    // Readies depend only on registered state plus the requester inputs.
    // They are also held low while RST is asserted so that no requester
    // believes a byte was taken during the reset cycle.
    always_comb begin
        w_grant_ok   = !RST && !r_busy && !bus.halt;
        w_data_ready = w_grant_ok && bus.data_valid &&
                       (!bus.stat_valid || r_last_grant);
        w_stat_ready = w_grant_ok && bus.stat_valid &&
                       (!bus.data_valid || !r_last_grant);
        w_load       = w_data_ready || w_stat_ready;
        w_byte       = w_stat_ready ? bus.stat_byte : bus.data_byte;
    end

    // busy mirrors "serializer not in IDLE": set on the accept edge and
    // cleared on the edge that leaves the stop bit.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            r_busy       <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_load) begin
            r_busy       <= 1'b1;
            r_owner      <= w_stat_ready;
            r_last_grant <= w_stat_ready;
        end else if (w_done) begin
            r_busy       <= 1'b0;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_serializer (
        .CLK_50M (CLK_50M),
        .RST     (RST),
        .i_load  (w_load),
        .i_byte  (w_byte),
        .o_txd   (w_txd),
        .o_done  (w_done)
    );

    assign bus.data_ready    = w_data_ready;
    assign bus.stat_ready    = w_stat_ready;
    assign bus.RS232_DCE_TXD = w_txd;
    assign bus.busy          = r_busy;
    assign bus.owner         = r_owner;

endmodule
`default_nettype wire
